// File: rtl/z80_dma_busmaster.sv
// ============================================================================
// Module      : z80_dma_busmaster
// Description : Single-channel memory-to-memory DMA engine that borrows the
//               Z80 bus via busrq_n/busak_n and copies a byte block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module z80_dma_busmaster #(
    parameter int ACK_TIMEOUT = 1024,
    parameter int TIMEOUT_W   = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] src,
    input  logic [15:0] dst,
    input  logic [15:0] len,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        busrq_n,
    input  logic        busak_n,
    output logic        bus_own,
    output logic [15:0] dma_a,
    output logic [7:0]  dma_do,
    input  logic [7:0]  dma_di,
    output logic        dma_mreq_n,
    output logic        dma_rd_n,
    output logic        dma_wr_n
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_RD   = 3'd2,
        S_CAP  = 3'd3,
        S_WR   = 3'd4,
        S_REL  = 3'd5
    } state_t;

    localparam logic [TIMEOUT_W-1:0] C_TIMEOUT_LAST = TIMEOUT_W'(ACK_TIMEOUT - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [15:0]          r_src;
    logic [15:0]          r_dst;
    logic [15:0]          r_rem;
    logic [TIMEOUT_W-1:0] r_cnt;
    logic [7:0]           r_data;
    logic                 r_err;
    logic                 r_zero_done;

    logic w_accept;
    logic w_zero;
    logic w_step;
    logic w_abort;
    logic w_in_xfer;

    assign w_accept  = (r_state == S_IDLE) && start && (len != 16'h0000);
    assign w_zero    = (r_state == S_IDLE) && start && (len == 16'h0000);
    assign w_in_xfer = (r_state == S_RD) || (r_state == S_CAP) || (r_state == S_WR);
    assign w_step    = (r_state == S_WR) && !busak_n;
    // Abort covers both the grant timeout and a grant withdrawn mid-copy.
    assign w_abort   = ((r_state == S_REQ) && busak_n && (r_cnt == C_TIMEOUT_LAST))
                     || (w_in_xfer && busak_n);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = S_REQ;
            S_REQ: begin
                if (!busak_n)
                    w_state_nxt = S_RD;
                else if (r_cnt == C_TIMEOUT_LAST)
                    w_state_nxt = S_REL;
            end
            S_RD:  w_state_nxt = busak_n ? S_REL : S_CAP;
            S_CAP: w_state_nxt = busak_n ? S_REL : S_WR;
            S_WR: begin
                if (busak_n || (r_rem == 16'h0001))
                    w_state_nxt = S_REL;
                else
                    w_state_nxt = S_RD;
            end
            S_REL:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_src       <= 16'h0000;
            r_dst       <= 16'h0000;
            r_rem       <= 16'h0000;
            r_cnt       <= '0;
            r_data      <= 8'h00;
            r_err       <= 1'b0;
            r_zero_done <= 1'b0;
        end else begin
            r_zero_done <= w_zero;
            if (w_accept) begin
                r_src <= src;
                r_dst <= dst;
                r_rem <= len;
                r_cnt <= '0;
                r_err <= 1'b0;
            end
            if (r_state == S_REQ)
                r_cnt <= r_cnt + 1'b1;
            if (r_state == S_CAP)
                r_data <= dma_di;
            if (w_step) begin
                r_src <= r_src + 16'h0001;
                r_dst <= r_dst + 16'h0001;
                r_rem <= r_rem - 16'h0001;
            end
            if (w_abort)
                r_err <= 1'b1;
        end
    end

    // Strobes are gated by the live grant so a withdrawn bus never sees a cycle.
    always_comb begin
        busrq_n    = 1'b1;
        bus_own    = 1'b0;
        dma_a      = 16'h0000;
        dma_mreq_n = 1'b1;
        dma_rd_n   = 1'b1;
        dma_wr_n   = 1'b1;
        case (r_state)
            S_REQ: busrq_n = 1'b0;
            S_RD: begin
                busrq_n    = 1'b0;
                bus_own    = 1'b1;
                dma_a      = r_src;
                dma_mreq_n = busak_n;
                dma_rd_n   = busak_n;
            end
            S_CAP: begin
                busrq_n = 1'b0;
                bus_own = 1'b1;
            end
            S_WR: begin
                busrq_n    = 1'b0;
                bus_own    = 1'b1;
                dma_a      = r_dst;
                dma_mreq_n = busak_n;
                dma_wr_n   = busak_n;
            end
            default: ;
        endcase
    end

    assign dma_do = r_data;
    assign err    = r_err;
    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_REL) || r_zero_done;

endmodule

`default_nettype wire
